conv_result_writer: RTL and testbench

CONV_RESULT_WRITER -- requirements
Module: conv_result_writer

---
 rtl/conv_result_writer_pkg.sv | 19 +
 rtl/conv_result_writer_fifo.sv | 53 +++++
 rtl/conv_result_writer.sv | 179 +++++++++++++++++
 tb/tb_conv_result_writer.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_result_writer_pkg.sv
// Shared defaults, FSM state encoding and sizing helper for the convolution result writer.
package conv_result_writer_pkg;

  localparam int unsigned S2P_SIZE_DEF    = 4;
  localparam int unsigned RESULT_SIZE_DEF = 32;
  localparam int unsigned ADDR_W_DEF      = 16;
  localparam int unsigned FIFO_DEPTH_DEF  = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Width able to hold a word index 0..s2p*s2p inclusive.
  function automatic int unsigned word_cnt_w(input int unsigned s2p);
    return $clog2(s2p * s2p + 1);
  endfunction

endpackage

// File: rtl/conv_result_writer_fifo.sv
// Synchronous write FIFO; DEPTH must be a power of two so the pointers wrap naturally.
module result_wr_fifo #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data_c,
  output logic                   full_c,
  output logic                   empty_c,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             wr_ok_c;
  logic             rd_ok_c;

  // A push on a full FIFO only lands when a pop frees the slot in the same cycle.
  assign rd_ok_c     = pop && !empty_c;
  assign wr_ok_c     = push && (!full_c || rd_ok_c);
  assign full_c      = (count == FULL_CNT);
  assign empty_c     = (count == '0);
  assign head_data_c = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok_c) wr_ptr <= wr_ptr + PW'(1);
      if (rd_ok_c) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_ok_c, rd_ok_c})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok_c) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/conv_result_writer.sv
// Maps serial tile result words onto output-memory addresses and streams them
// through a FIFO to a ready/valid memory write port.
module conv_result_writer
  import conv_result_writer_pkg::*;
#(
  parameter int unsigned S2P_SIZE    = S2P_SIZE_DEF,
  parameter int unsigned RESULT_SIZE = RESULT_SIZE_DEF,
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      out_pixels,
  input  logic [ADDR_W-1:0]      kernel_nums,
  input  logic [ADDR_W-1:0]      tile_nums,
  input  logic [ADDR_W-1:0]      t_tile_nums,
  input  logic [RESULT_SIZE-1:0] in_result,
  input  logic [2:0]             in_result_valid,
  output logic                   mem_wr_en,
  output logic [ADDR_W-1:0]      mem_wr_addr,
  output logic [RESULT_SIZE-1:0] mem_wr_data,
  input  logic                   mem_wr_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
);

  localparam int unsigned KW = word_cnt_w(S2P_SIZE);
  localparam int unsigned FW = ADDR_W + RESULT_SIZE;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [KW-1:0] K_LAST = KW'(S2P_SIZE * S2P_SIZE - 1);

  logic [1:0]             state_q;
  logic [1:0]             state_n;
  logic [KW-1:0]          k_q;
  logic [KW-1:0]          k_eff_c;
  logic [ADDR_W-1:0]      t_idx_q;
  logic [ADDR_W-1:0]      w_idx_q;
  logic [ADDR_W-1:0]      tile_cnt_q;
  logic [ADDR_W-1:0]      row_c;
  logic [ADDR_W-1:0]      col_c;
  logic [ADDR_W-1:0]      pixel_c;
  logic [ADDR_W-1:0]      kernel_c;
  logic                   acc_c;
  logic                   start_ok_c;
  logic                   keep_c;
  logic                   last_word_c;
  logic                   last_tile_c;
  logic                   push_q;
  logic [ADDR_W-1:0]      push_addr_q;
  logic [RESULT_SIZE-1:0] push_data_q;
  logic                   fifo_pop_c;
  logic                   fifo_full_c;
  logic                   fifo_empty_c;
  logic [FW-1:0]          fifo_head_c;
  logic [CW-1:0]          fifo_count;

  // Word position decode; a tile-start word always restarts at index 0.
  always_comb begin
    acc_c       = (state_q == ST_RUN) && in_result_valid[1];
    start_ok_c  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    k_eff_c     = in_result_valid[2] ? '0 : k_q;
    row_c       = ADDR_W'(k_eff_c % KW'(S2P_SIZE));
    col_c       = ADDR_W'(k_eff_c / KW'(S2P_SIZE));
    pixel_c     = t_idx_q * ADDR_W'(S2P_SIZE) + row_c;
    kernel_c    = w_idx_q * ADDR_W'(S2P_SIZE) + col_c;
    keep_c      = in_result_valid[0] && (kernel_c < kernel_nums) && (pixel_c < out_pixels);
    last_word_c = (k_eff_c == K_LAST);
    last_tile_c = (tile_cnt_q == tile_nums - ADDR_W'(1));
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE,
      ST_DONE:  if (start_ok_c) state_n = ST_RUN;
      ST_RUN:   if (acc_c && last_word_c && last_tile_c) state_n = ST_DRAIN;
      ST_DRAIN: if (!push_q && (fifo_count == '0) && (!mem_wr_en || mem_wr_ready))
                  state_n = ST_DONE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_n;
      busy    <= (state_n == ST_RUN) || (state_n == ST_DRAIN);
      done    <= (state_n == ST_DONE);
    end
  end

  // Tile position counters: t_idx walks the t-tiles inside each w-tile.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      k_q        <= '0;
      t_idx_q    <= '0;
      w_idx_q    <= '0;
      tile_cnt_q <= '0;
    end else if (start_ok_c) begin
      k_q        <= '0;
      t_idx_q    <= '0;
      w_idx_q    <= '0;
      tile_cnt_q <= '0;
    end else if (acc_c) begin
      k_q <= last_word_c ? '0 : k_eff_c + KW'(1);
      if (last_word_c) begin
        tile_cnt_q <= tile_cnt_q + ADDR_W'(1);
        if (t_idx_q == t_tile_nums - ADDR_W'(1)) begin
          t_idx_q <= '0;
          w_idx_q <= w_idx_q + ADDR_W'(1);
        end else begin
          t_idx_q <= t_idx_q + ADDR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      push_q      <= 1'b0;
      push_addr_q <= '0;
      push_data_q <= '0;
    end else begin
      push_q <= acc_c && keep_c;
      if (acc_c) begin
        push_addr_q <= kernel_c * out_pixels + pixel_c;
        push_data_q <= in_result;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      overflow <= 1'b0;
    end else if (start_ok_c) begin
      overflow <= 1'b0;
    end else if (push_q && fifo_full_c && !fifo_pop_c) begin
      overflow <= 1'b1;
    end
  end

  result_wr_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rstn        (rstn),
    .push        (push_q),
    .push_data   ({push_addr_q, push_data_q}),
    .pop         (fifo_pop_c),
    .head_data_c (fifo_head_c),
    .full_c      (fifo_full_c),
    .empty_c     (fifo_empty_c),
    .count       (fifo_count)
  );

  // Output stage refills from the FIFO head whenever it is empty or being accepted.
  assign fifo_pop_c = !fifo_empty_c && (!mem_wr_en || mem_wr_ready);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
    end else if (fifo_pop_c) begin
      mem_wr_en   <= 1'b1;
      mem_wr_addr <= fifo_head_c[FW-1 -: ADDR_W];
      mem_wr_data <= fifo_head_c[RESULT_SIZE-1:0];
    end else if (mem_wr_ready) begin
      mem_wr_en   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_result_writer.sv
// Directed bench for conv_result_writer: address mapping, padding, backpressure, overflow, reset.
module tb_conv_result_writer;

  localparam int unsigned S2P = 4;
  localparam int unsigned RW  = 32;
  localparam int unsigned AW  = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic [AW-1:0] out_pixels;
  logic [AW-1:0] kernel_nums;
  logic [AW-1:0] tile_nums;
  logic [AW-1:0] t_tile_nums;
  logic [RW-1:0] in_result;
  logic [2:0]    in_result_valid;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [RW-1:0] mem_wr_data;
  logic          mem_wr_ready;
  logic          busy;
  logic          done;
  logic          overflow;

  int checks = 0;
  int errors = 0;
  int cfg_op, cfg_kn, cfg_tt;
  bit cfg_pad;

  logic [AW-1:0] exp_addr[$];
  logic [AW-1:0] obs_addr[$];
  logic [RW-1:0] exp_data[$];
  logic [RW-1:0] obs_data[$];

  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_addr  = '0;
  logic [RW-1:0] prev_data  = '0;

  always #5 clk = ~clk;

  conv_result_writer #(
    .S2P_SIZE    (S2P),
    .RESULT_SIZE (RW),
    .ADDR_W      (AW),
    .FIFO_DEPTH  (16)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .start           (start),
    .out_pixels      (out_pixels),
    .kernel_nums     (kernel_nums),
    .tile_nums       (tile_nums),
    .t_tile_nums     (t_tile_nums),
    .in_result       (in_result),
    .in_result_valid (in_result_valid),
    .mem_wr_en       (mem_wr_en),
    .mem_wr_addr     (mem_wr_addr),
    .mem_wr_data     (mem_wr_data),
    .mem_wr_ready    (mem_wr_ready),
    .busy            (busy),
    .done            (done),
    .overflow        (overflow)
  );

  // Collect accepted writes and check that stalled requests do not change.
  always @(negedge clk) begin
    if (rstn && prev_stall && mem_wr_en) begin
      checks++;
      if (mem_wr_addr !== prev_addr || mem_wr_data !== prev_data) begin
        errors++;
        $display("FAIL hold_stable: addr %0d data %h, required addr %0d data %h",
                 mem_wr_addr, mem_wr_data, prev_addr, prev_data);
      end
    end
    if (rstn && mem_wr_en && mem_wr_ready) begin
      obs_addr.push_back(mem_wr_addr);
      obs_data.push_back(mem_wr_data);
    end
    prev_stall = rstn && mem_wr_en && !mem_wr_ready;
    prev_addr  = mem_wr_addr;
    prev_data  = mem_wr_data;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_layer(input int op, input int kn, input int tn, input int tt, input bit pad);
    out_pixels  = AW'(op);
    kernel_nums = AW'(kn);
    tile_nums   = AW'(tn);
    t_tile_nums = AW'(tt);
    cfg_op = op; cfg_kn = kn; cfg_tt = tt; cfg_pad = pad;
    exp_addr.delete(); exp_data.delete();
    obs_addr.delete(); obs_data.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Drive one word of tile n at index k and record its expected write, if any.
  task automatic drive_word(input int n, input int k);
    int t, w, pix, ker;
    bit keep;
    t   = n % cfg_tt;
    w   = n / cfg_tt;
    pix = t * S2P + k % S2P;
    ker = w * S2P + k / S2P;
    keep = cfg_pad ? (pix < cfg_op) : 1'b1;
    in_result       = RW'(32'h5A00_0000 + n * 256 + k);
    in_result_valid = {k == 0, 1'b1, keep};
    if (keep && ker < cfg_kn && pix < cfg_op) begin
      exp_addr.push_back(AW'(ker * cfg_op + pix));
      exp_data.push_back(in_result);
    end
    tick();
    in_result_valid = 3'b000;
  endtask

  task automatic drive_tiles(input int nt);
    for (int n = 0; n < nt; n++)
      for (int k = 0; k < S2P * S2P; k++)
        drive_word(n, k);
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; in_result = '0; in_result_valid = 3'b000;
    mem_wr_ready = 1'b1;
    out_pixels = '0; kernel_nums = '0; tile_nums = '0; t_tile_nums = '0;
    repeat (3) tick();
    checks++;
    if ({mem_wr_en, busy, done, overflow} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: en/busy/done/ovf %b, required 0000", {mem_wr_en, busy, done, overflow});
    end
    checks++;
    if (mem_wr_addr !== 16'd0) begin
      errors++; $display("FAIL reset_addr: %0d, required 0", mem_wr_addr);
    end
    checks++;
    if (mem_wr_data !== 32'd0) begin
      errors++; $display("FAIL reset_data: %h, required 0", mem_wr_data);
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_full_layer();
    bit ok;
    int bad, mism, sz;
    int cnt[64];
    start_layer(16, 4, 4, 4, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL full_busy: %b, required 1", busy);
    end
    drive_tiles(4);
    wait_done(ok);
    sz = obs_addr.size();
    checks++;
    if (!ok || busy !== 1'b0) begin
      errors++; $display("FAIL full_done: done seen %0d busy %b, required 1 and 0", ok, busy);
    end
    checks++;
    if (sz != 64) begin
      errors++; $display("FAIL full_count_at_done: %0d writes, required 64", sz);
    end
    foreach (cnt[i]) cnt[i] = 0;
    bad = 0;
    foreach (obs_addr[i]) begin
      if (obs_addr[i] < 16'd64) cnt[obs_addr[i][5:0]]++;
      else bad++;
    end
    foreach (cnt[i]) if (cnt[i] != 1) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL full_addr_once: %0d bad addresses, required 0", bad);
    end
    mism = 0;
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++)
      if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) mism++;
    checks++;
    if (mism != 0) begin
      errors++; $display("FAIL full_order: %0d mismatching writes, required 0", mism);
    end
    repeat (5) tick();
    checks++;
    if (obs_addr.size() != 64 || done !== 1'b1) begin
      errors++;
      $display("FAIL full_after_done: %0d writes done %b, required 64 and 1", obs_addr.size(), done);
    end
  endtask

  task automatic test_latency();
    bit ok;
    int mism;
    start_layer(4, 4, 1, 1, 1'b0);
    drive_word(0, 0);
    checks++;
    if (mem_wr_en !== 1'b0) begin
      errors++; $display("FAIL lat_cycle1: en %b, required 0", mem_wr_en);
    end
    tick();
    checks++;
    if (mem_wr_en !== 1'b0) begin
      errors++; $display("FAIL lat_cycle2: en %b, required 0", mem_wr_en);
    end
    tick();
    checks++;
    if (mem_wr_en !== 1'b1 || mem_wr_addr !== 16'd0 || mem_wr_data !== 32'h5A00_0000) begin
      errors++;
      $display("FAIL lat_first_write: en %b addr %0d data %h, required 1 0 5a000000",
               mem_wr_en, mem_wr_addr, mem_wr_data);
    end
    for (int k = 1; k < 16; k++) drive_word(0, k);
    wait_done(ok);
    mism = 0;
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++)
      if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) mism++;
    checks++;
    if (!ok || obs_addr.size() != 16 || mism != 0) begin
      errors++;
      $display("FAIL lat_tile: done %0d writes %0d mism %0d, required 1 16 0", ok, obs_addr.size(), mism);
    end
  endtask

  task automatic test_pixel_pad();
    bit ok;
    int hi, mism;
    start_layer(14, 4, 4, 4, 1'b1);
    drive_tiles(4);
    wait_done(ok);
    hi = 0;
    foreach (obs_addr[i]) if (obs_addr[i] >= 16'd56) hi++;
    checks++;
    if (!ok || obs_addr.size() != 56) begin
      errors++; $display("FAIL pix_count: done %0d writes %0d, required 1 56", ok, obs_addr.size());
    end
    checks++;
    if (hi != 0) begin
      errors++; $display("FAIL pix_range: %0d addresses >= 56, required 0", hi);
    end
    mism = 0;
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++)
      if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) mism++;
    checks++;
    if (mism != 0) begin
      errors++; $display("FAIL pix_order: %0d mismatching writes, required 0", mism);
    end
  endtask

  task automatic test_kernel_pad();
    bit ok;
    int mism;
    logic [AW-1:0] amax;
    start_layer(4, 6, 2, 1, 1'b0);
    drive_tiles(2);
    wait_done(ok);
    amax = '0;
    foreach (obs_addr[i]) if (obs_addr[i] > amax) amax = obs_addr[i];
    checks++;
    if (!ok || obs_addr.size() != 24) begin
      errors++; $display("FAIL ker_count: done %0d writes %0d, required 1 24", ok, obs_addr.size());
    end
    checks++;
    if (amax !== 16'd23) begin
      errors++; $display("FAIL ker_max_addr: %0d, required 23", amax);
    end
    mism = 0;
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++)
      if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) mism++;
    checks++;
    if (mism != 0) begin
      errors++; $display("FAIL ker_order: %0d mismatching writes, required 0", mism);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int mism;
    start_layer(4, 4, 1, 1, 1'b0);
    fork
      drive_tiles(1);
      begin
        mem_wr_ready = 1'b0;
        repeat (10) tick();
        mem_wr_ready = 1'b1;
      end
    join
    wait_done(ok);
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL bp_overflow: %b, required 0", overflow);
    end
    mism = 0;
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++)
      if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) mism++;
    checks++;
    if (!ok || obs_addr.size() != 16 || mism != 0) begin
      errors++;
      $display("FAIL bp_order: done %0d writes %0d mism %0d, required 1 16 0", ok, obs_addr.size(), mism);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    start_layer(16, 4, 4, 4, 1'b0);
    fork
      drive_tiles(4);
      begin
        mem_wr_ready = 1'b0;
        repeat (40) tick();
        mem_wr_ready = 1'b1;
      end
    join
    wait_done(ok);
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_flag: %b, required 1", overflow);
    end
    checks++;
    if (!ok || obs_addr.size() >= 64 || obs_addr.size() == 0) begin
      errors++; $display("FAIL ovf_writes: done %0d writes %0d, required 1 and 1..63", ok, obs_addr.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int mism;
    start_layer(16, 4, 4, 4, 1'b0);
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL start_clears_ovf: %b, required 0", overflow);
    end
    for (int k = 0; k < 8; k++) drive_word(0, k);
    rstn = 1'b0;
    tick();
    checks++;
    if ({mem_wr_en, busy, done, overflow} !== 4'b0000) begin
      errors++;
      $display("FAIL mid_rst_flags: en/busy/done/ovf %b, required 0000", {mem_wr_en, busy, done, overflow});
    end
    checks++;
    if (mem_wr_addr !== 16'd0 || mem_wr_data !== 32'd0) begin
      errors++; $display("FAIL mid_rst_bus: addr %0d data %h, required 0 0", mem_wr_addr, mem_wr_data);
    end
    rstn = 1'b1;
    repeat (3) tick();
    start_layer(16, 4, 4, 4, 1'b0);
    drive_tiles(4);
    wait_done(ok);
    mism = 0;
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++)
      if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) mism++;
    checks++;
    if (!ok || obs_addr.size() != 64 || mism != 0) begin
      errors++;
      $display("FAIL mid_rst_rerun: done %0d writes %0d mism %0d, required 1 64 0", ok, obs_addr.size(), mism);
    end
    checks++;
    if (obs_addr.size() == 0 || obs_addr[0] !== 16'd0) begin
      errors++; $display("FAIL mid_rst_first_addr: writes %0d, required first address 0", obs_addr.size());
    end
  endtask

  initial begin
    test_reset();
    test_full_layer();
    test_latency();
    test_pixel_pad();
    test_kernel_pad();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
